iir_inverse_filter: RTL

IIR_INVERSE_FILTER -- requirements
Module: iir_inverse_filter

---
 rtl/filt_pkg.sv | 15 +
 rtl/iir_history.sv | 42 ++++
 rtl/iir_inverse_filter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/filt_pkg.sv
// Shared types and constants for the IIR inverse filter.
package filt_pkg;

    // 32-bit two's complement sample; all arithmetic wraps at this width.
    typedef logic signed [31:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int M_DEFAULT = 4;

endpackage

// File: rtl/iir_history.sv
// M-deep delay line of past outputs; shifts once per output handshake,
// all taps readable in parallel. taps[0] is the most recent output.
module iir_history
    import filt_pkg::*;
#(
    parameter int M = M_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    shift_en,
    input  sample_t din,
    output sample_t taps [0:M-1]
);

    sample_t hist_q [0:M-1];
    sample_t hist_d [0:M-1];

    // Next history: push din at the front when shifting, otherwise hold.
    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d[0] = din;
            for (int i = 1; i < M; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // History register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < M; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            hist_q <= hist_d;
        end
    end

    assign taps = hist_q;

endmodule

// File: rtl/iir_inverse_filter.sv
// All-pole IIR that undoes a monic FIR encoder:
//   y[n] = x[n] - sum(k=1..M) coeffs[k] * y[n-k]
// One shared multiplier walks the taps, one per MAC cycle.
//
// state | meaning
// IDLE  | waiting for din; din_ready high once out of reset
// MAC   | accumulating tap k (k = 1..M), one tap per cycle
// OUT   | result on dout, held until dout_ready
//
// An accepted sample spends its acceptance cycle plus M MAC cycles before
// OUT is entered; OUT lasts at least one cycle, so back-to-back throughput
// is one sample per M+2 cycles.
module iir_inverse_filter
    import filt_pkg::*;
#(
    parameter int M = M_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] coeffs [0:M],
    input  logic signed [31:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic signed [31:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready
);

    state_t   state_q, state_d;
    logic [3:0] k_q, k_d;
    sample_t  acc_q, acc_d;
    sample_t  snap_q [0:M-1];
    sample_t  snap_d [0:M-1];
    // Low during reset so din_ready only rises on the first edge after release.
    logic     init_q, init_d;

    sample_t  hist_taps [0:M-1];
    sample_t  snap_sel;
    sample_t  hist_sel;
    sample_t  prod;
    logic     accept;
    logic     hist_shift;

    assign accept     = (state_q == IDLE) && init_q && din_valid;
    assign hist_shift = (state_q == OUT) && dout_ready;

    iir_history #(.M(M)) u_history (
        .clk      (clk),
        .reset    (reset),
        .shift_en (hist_shift),
        .din      (acc_q),
        .taps     (hist_taps)
    );

    // Route coefficient k and output y[n-k] to the single multiplier.
    always_comb begin
        snap_sel = '0;
        hist_sel = '0;
        for (int i = 0; i < M; i++) begin
            if (k_q == 4'(i + 1)) begin
                snap_sel = snap_q[i];
                hist_sel = hist_taps[i];
            end
        end
    end

    // 32-bit product; upper bits are discarded so the result wraps.
    assign prod = snap_sel * hist_sel;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (k_q == 4'(M)) state_d = OUT;
            OUT:     if (dout_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, accumulate in MAC, hold in OUT.
    always_comb begin
        acc_d  = acc_q;
        k_d    = k_q;
        snap_d = snap_q;
        init_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = din;
                    k_d   = 4'd1;
                    for (int i = 0; i < M; i++) begin
                        snap_d[i] = coeffs[i+1];
                    end
                end
            end
            MAC: begin
                acc_d = acc_q - prod;
                k_d   = k_q + 4'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            k_q    <= '0;
            init_q <= 1'b0;
            for (int i = 0; i < M; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            acc_q  <= acc_d;
            k_q    <= k_d;
            init_q <= init_d;
            snap_q <= snap_d;
        end
    end

    // Output decode from the current state.
    always_comb begin
        din_ready  = (state_q == IDLE) && init_q;
        dout_valid = (state_q == OUT);
        dout       = acc_q;
    end

endmodule
